// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-tap majority sampler around the bit centre, with a one-cycle sample-valid pulse
// following the last tap.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] edge_count,
  input  logic [PRESC_W-1:0] prescale,
  output logic               sampled,
  output logic               samp_vld
);

  logic [PRESC_W-1:0] half;
  logic               tap0_q, tap1_q, sampled_q;

  assign half = prescale >> 1;

  // The third tap feeds the vote directly, so the result lands one edge after it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tap0_q    <= 1'b0;
      tap1_q    <= 1'b0;
      sampled_q <= 1'b0;
    end else begin
      if (edge_count == half - PRESC_W'(1)) tap0_q <= RX_IN;
      if (edge_count == half) tap1_q <= RX_IN;
      if (edge_count == half + PRESC_W'(1)) sampled_q <= maj3(tap0_q, tap1_q, RX_IN);
    end
  end

  assign sampled  = sampled_q;
  assign samp_vld = (edge_count == half + PRESC_W'(2));

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control: frame FSM, LSB-first deserializer, parity/stop checks.
// Optional break detection output enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic [PRESC_W-1:0]    edge_count,
  input  logic [3:0]            bit_count,
  output logic                  cnt_enable,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic                  break_det
`endif
);

  rx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  sampled, samp_vld, edge_done, par_exp;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                  par_bit_q, par_bit_d;
  logic                  break_q, break_d;
`endif

  uart_rx_sampler #(
    .PRESC_W(PRESC_W)
  ) u_sampler (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .edge_count(edge_count),
    .prescale  (prescale),
    .sampled   (sampled),
    .samp_vld  (samp_vld)
  );

  assign edge_done  = (edge_count == prescale - PRESC_W'(1));
  assign cnt_enable = (state_q != IDLE) && (state_q != DONE);
  assign par_exp    = (PAR_TYP == PAR_EVEN) ? ^shift_q : ~^shift_q;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;
`ifdef UART_RX_BREAK_DETECT_EN
    par_bit_d    = par_bit_q;
    break_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          state_d   = START;
          shift_d   = '0;
          par_err_d = 1'b0;
          stp_err_d = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
          par_bit_d = 1'b0;
`endif
        end
      end
      START: begin
        // A start bit that reads high at its centre was a glitch.
        if (samp_vld && sampled) begin
          state_d = IDLE;
        end else if (edge_done) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (samp_vld) begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bit_count == 4'(i + 1)) shift_d[i] = sampled;
          end
        end
        if (edge_done && bit_count == 4'(DATA_WIDTH)) begin
          state_d = PAR_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (samp_vld) begin
          if (sampled != par_exp) par_err_d = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
          par_bit_d = sampled;
`endif
        end
        if (edge_done) state_d = STOP;
      end
      STOP: begin
        // Leave at mid-stop so an immediately following start edge is still seen in IDLE.
        if (samp_vld) begin
          state_d   = DONE;
          stp_err_d = ~sampled;
          if (!par_err_q && sampled) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
`ifdef UART_RX_BREAK_DETECT_EN
          break_d = (shift_q == '0) && !(PAR_EN && par_bit_q) && !sampled;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result registers load on the STOP->DONE edge, so the strobe is visible during DONE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      par_bit_q    <= 1'b0;
      break_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
`ifdef UART_RX_BREAK_DETECT_EN
      par_bit_q    <= par_bit_d;
      break_q      <= break_d;
`endif
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
`ifdef UART_RX_BREAK_DETECT_EN
  assign break_det  = break_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural edge/bit counter and a byte scoreboard.
module tb_uart_rx_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 6;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [PW-1:0] prescale;
  logic [PW-1:0] edge_count;
  logic [3:0]    bit_count;
  logic          cnt_enable;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
`ifdef UART_RX_BREAK_DETECT_EN
  logic          break_det;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [DW-1:0] sb[$];
  int            n_strobe = 0;
  int            cyc = 0;
  int            t_stop = 0;
  bit            armed = 0;
  bit            snap_seen = 0;
  bit            prev_dv = 0;
  logic          snap_par, snap_stp, snap_brk;
  logic [DW-1:0] snap_data;

  uart_rx_ctrl #(
    .DATA_WIDTH(DW),
    .PRESC_W   (PW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .prescale  (prescale),
    .edge_count(edge_count),
    .bit_count (bit_count),
    .cnt_enable(cnt_enable),
    .P_DATA    (P_DATA),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stp_err   (stp_err)
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    .break_det (break_det)
`endif
  );

  always #5 CLK = ~CLK;

  // Edge/bit counter that the controller drives through cnt_enable.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (!cnt_enable) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (edge_count == prescale - 6'd1) begin
      edge_count <= '0;
      bit_count  <= bit_count + 4'd1;
    end else begin
      edge_count <= edge_count + 6'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: stop-bit timing reference, end-of-frame snapshot, scoreboard pops.
  always @(negedge CLK) begin
    int lat;
    cyc++;
    lat = int'(prescale) / 2 + 3;
    if (cnt_enable && edge_count == '0 && bit_count == (PAR_EN ? 4'd10 : 4'd9)) begin
      t_stop = cyc;
      armed  = 1'b1;
    end
    if (armed && cyc == t_stop + lat) begin
      snap_par  = par_err;
      snap_stp  = stp_err;
      snap_data = P_DATA;
`ifdef UART_RX_BREAK_DETECT_EN
      snap_brk  = break_det;
`else
      snap_brk  = 1'b0;
`endif
      snap_seen = 1'b1;
      armed     = 1'b0;
    end
    if (data_valid) begin
      n_strobe++;
      check("dv_single_cycle", 32'(prev_dv), 32'd0);
      check("dv_latency", 32'(cyc - t_stop), 32'(lat));
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("p_data", 32'(P_DATA), 32'(sb.pop_front()));
    end
    prev_dv = data_valid;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    RX_IN = b;
    idle(int'(prescale));
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input logic par_bit,
                            input logic stop_bit, input bit good);
    snap_seen = 1'b0;
    if (good) sb.push_back(data);
    drive_bit(1'b0);
    for (int i = 0; i < int'(DW); i++) drive_bit(data[i]);
    if (PAR_EN) drive_bit(par_bit);
    drive_bit(stop_bit);
    RX_IN = 1'b1;
  endtask

  task automatic frame_check(input string tag, input logic par, input logic stp,
                             input logic brk, input logic [DW-1:0] data);
    check({tag, "_seen"}, 32'(snap_seen), 32'd1);
    check({tag, "_par_err"}, 32'(snap_par), 32'(par));
    check({tag, "_stp_err"}, 32'(snap_stp), 32'(stp));
    check({tag, "_p_data"}, 32'(snap_data), 32'(data));
`ifdef UART_RX_BREAK_DETECT_EN
    check({tag, "_break"}, 32'(snap_brk), 32'(brk));
`else
    if (brk) check({tag, "_break_unused"}, 32'(snap_brk), 32'd0);
`endif
  endtask

  initial begin
    logic [DW-1:0] abort_byte;
    int            n_good;
    n_good   = 0;
    RST      = 1'b1;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    prescale = 6'd8;
    idle(3);
    check("rst_p_data", 32'(P_DATA), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_par_err", 32'(par_err), 32'd0);
    check("rst_stp_err", 32'(stp_err), 32'd0);
    check("rst_cnt_enable", 32'(cnt_enable), 32'd0);
    RST = 1'b0;
    idle(4);

    // prescale 8, no parity
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1); n_good++;
    idle(6);
    frame_check("a5", 1'b0, 1'b0, 1'b0, 8'hA5);

    // prescale 16, even parity good then bad, then odd parity good
    prescale = 6'd16;
    PAR_EN   = 1'b1;
    PAR_TYP  = 1'b0;
    idle(4);
    send_frame(8'h37, 1'b1, 1'b1, 1'b1); n_good++;
    idle(6);
    frame_check("even_ok", 1'b0, 1'b0, 1'b0, 8'h37);
    send_frame(8'h37, 1'b0, 1'b1, 1'b0);
    idle(6);
    frame_check("even_bad", 1'b1, 1'b0, 1'b0, 8'h37);
    PAR_TYP = 1'b1;
    idle(4);
    send_frame(8'h36, 1'b1, 1'b1, 1'b1); n_good++;
    idle(6);
    frame_check("odd_ok", 1'b0, 1'b0, 1'b0, 8'h36);

    // prescale 32, stop error then clean frame
    prescale = 6'd32;
    PAR_EN   = 1'b0;
    idle(4);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    idle(6);
    frame_check("stop_bad", 1'b0, 1'b1, 1'b0, 8'h36);
    idle(96);
    send_frame(8'h11, 1'b0, 1'b1, 1'b1); n_good++;
    idle(6);
    frame_check("after_err", 1'b0, 1'b0, 1'b0, 8'h11);

    // Start glitch, prescale 16
    prescale = 6'd16;
    idle(4);
    RX_IN = 1'b0;
    idle(3);
    RX_IN = 1'b1;
    check("glitch_start", 32'(cnt_enable), 32'd1);
    idle(20);
    check("glitch_idle", 32'(cnt_enable), 32'd0);
    check("glitch_par_err", 32'(par_err), 32'd0);
    check("glitch_stp_err", 32'(stp_err), 32'd0);
    check("glitch_p_data", 32'(P_DATA), 32'h11);

    // Back-to-back frames, next start one cycle after the stop bit
    send_frame(8'h01, 1'b0, 1'b1, 1'b1); n_good++;
    idle(1);
    send_frame(8'hFE, 1'b0, 1'b1, 1'b1); n_good++;
    idle(6);
    frame_check("b2b", 1'b0, 1'b0, 1'b0, 8'hFE);

    // Reset mid-frame at bit_count 4
    prescale   = 6'd8;
    idle(4);
    abort_byte = 8'h99;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(abort_byte[i]);
    RX_IN = abort_byte[3];
    for (int i = 0; i < 64 && bit_count != 4'd4; i++) idle(1);
    check("abort_reach_bit4", 32'(bit_count), 32'd4);
    RST = 1'b1;
    #2;
    check("abort_p_data", 32'(P_DATA), 32'd0);
    check("abort_data_valid", 32'(data_valid), 32'd0);
    check("abort_par_err", 32'(par_err), 32'd0);
    check("abort_stp_err", 32'(stp_err), 32'd0);
    check("abort_cnt_enable", 32'(cnt_enable), 32'd0);
    @(posedge CLK);
    #1;
    RST   = 1'b0;
    RX_IN = 1'b1;
    idle(20);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1); n_good++;
    idle(6);
    frame_check("post_rst", 1'b0, 1'b0, 1'b0, 8'h3C);

`ifdef UART_RX_BREAK_DETECT_EN
    send_frame(8'h00, 1'b0, 1'b0, 1'b0);
    idle(6);
    frame_check("break", 1'b0, 1'b1, 1'b1, 8'h3C);
    idle(24);
`endif

    idle(10);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("strobe_count", 32'(n_strobe), 32'(n_good));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side control core of the UART RX path.
- Drives the enable of the oversampling edge/bit counter and consumes its edge_count and bit_count.
- Majority-samples RX_IN, deserializes an LSB-first frame, checks start, parity and stop bits, and emits a parallel byte with a one-cycle valid strobe to the system controller.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal 5..8).
- PRESC_W, 6, width of the prescale and edge_count buses.

Ports:
- CLK  in  1  oversampling clock (prescale × baud).
- RST  in  1  asynchronous active-high reset.
- RX_IN  in  1  serial line, already synchronized upstream; idle high.
- PAR_EN  in  1  parity bit present in frame.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- prescale  in  PRESC_W  oversampling ratio; legal values 8, 16, 32.
- edge_count  in  PRESC_W  from counter: edge index within current bit.
- bit_count  in  4  from counter: bit index within frame (0 = start).
- cnt_enable  out  1  enable to the edge/bit counter; low clears the counter.
- P_DATA  out  DATA_WIDTH  last good received word.
- data_valid  out  1  one-cycle strobe; P_DATA is new.
- par_err  out  1  parity error of last frame.
- stp_err  out  1  stop-bit error of last frame.

Behaviour:
- Reset values: all outputs 0, state IDLE, shift register 0. Reset asserted mid-frame aborts the frame; no data_valid is produced.
- Sampling:
  - RX_IN is captured at edge_count = prescale/2-1, prescale/2 and prescale/2+1.
  - The sampled bit is the 2-of-3 majority, registered.
  - samp_vld pulses for one cycle when edge_count = prescale/2+2.
- edge_done = (edge_count == prescale-1).
- States and transitions:
  - IDLE: cnt_enable=0. RX_IN==0 → START, with cnt_enable=1 from the next cycle.
  - START: at samp_vld, sampled==1 → glitch, go to IDLE; no error flags, no strobe. Otherwise, at edge_done → DATA.
  - DATA: at samp_vld, shift sampled into bit position bit_count-1 (LSB first). At edge_done with bit_count==DATA_WIDTH → PARITY if PAR_EN, else STOP.
  - PARITY: at samp_vld, compare sampled with XOR of data (inverted when PAR_TYP=1). Mismatch → par_err register set. At edge_done → STOP.
  - STOP: at samp_vld, stp_err = ~sampled, then → DONE. The state exits at mid-stop so a back-to-back start edge is not missed.
  - DONE (1 cycle): cnt_enable=0.
    - No errors: P_DATA ← shift register and data_valid=1.
    - Otherwise: P_DATA is held and data_valid stays 0.
    - Then → IDLE.
- par_err and stp_err are cleared on entry to START. They otherwise hold, and both may be set together.
- PAR_EN, PAR_TYP and prescale must be stable while not in IDLE; changes mid-frame are undefined.
- Latency: data_valid occurs prescale/2+3 cycles after the first stop-bit edge.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- When defined: output port break_det (1 bit, reset 0). It pulses one cycle in DONE when all data bits, the parity bit (if present) and the stop sample are 0. In that case stp_err is still set and data_valid stays 0.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package uart_rx_pkg holds:
  - state enum rx_state_e {IDLE, START, DATA, PARITY, STOP, DONE};
  - localparam PAR_EVEN = 1'b0 and PAR_ODD = 1'b1.
- Natural sub-module: uart_rx_sampler (3-tap majority vote plus samp_vld generation, inputs RX_IN/edge_count/prescale). The FSM, deserializer and checks stay in uart_rx_ctrl.

Test Plan:
- prescale=8, PAR_EN=0, send 0xA5 with stop=1 → data_valid one cycle, P_DATA=0xA5, par_err=stp_err=0.
- prescale=16, PAR_EN=1, PAR_TYP=0, send 0x37 with parity 1 → P_DATA=0x37. Same frame with parity 0 → par_err=1, no data_valid, P_DATA unchanged.
- prescale=32, send 0x5A with stop=0 → stp_err=1, no data_valid. Then a good 0x11 frame → errors cleared at start, P_DATA=0x11.
- RX_IN low for 3 cycles then high (prescale=16) → START then IDLE, cnt_enable drops, no strobe, no error flags.
- Back-to-back frames 0x01 then 0xFE, with the start edge one cycle after the nominal stop end → both strobes, P_DATA 0x01 then 0xFE.
- Reset asserted at bit_count=4 → outputs 0, state IDLE. The next frame 0x3C is received correctly. With UART_RX_BREAK_DETECT_EN, an all-zero frame with stop=0 → break_det pulse, stp_err=1.
